decode_imm_stage: RTL and testbench

//  Decode-stage controller sitting between fetch and execute. Classifies each fetched
//  RV32I instruction by opcode and selects the immediate format (imm_type_e). Drives an

---
 rtl/decode_imm_stage.sv | 257 +++++++++++++++++++++++++
 tb/tb_decode_imm_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_imm_stage.sv
// Decode stage: classifies RV32I opcodes, builds the immediate, registers it into D/E.
// Latency: one cycle from input acceptance to o_valid; no combinational i_in_* -> o_* path.
// Backpressure: valid/ready both sides; optional 1-entry skid keeps full rate with a registered ready.

package decode_imm_pkg;

  typedef logic [31:0] inst_t;
  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IMM_TYPE_I   = 3'd0,
    IMM_TYPE_S   = 3'd1,
    IMM_TYPE_B   = 3'd2,
    IMM_TYPE_U   = 3'd3,
    IMM_TYPE_J   = 3'd4,
    IMM_TYPE_CSR = 3'd5
  } imm_type_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// Immediate generator: reassembles the immediate for the selected format.
// Latency: purely combinational.
// Backpressure: none; i_en low forces a clean zero.
module decode_imm_gen
  import decode_imm_pkg::*;
(
  input  logic [31:7] i_inst_hi,
  input  imm_type_e   i_type,
  input  logic        i_en,
  output word_t       o_imm
);

  // Format-specific bit shuffling and sign extension
  always_comb begin
    o_imm = '0;
    if (i_en) begin
      case (i_type)
        IMM_TYPE_I:   o_imm = {{20{i_inst_hi[31]}}, i_inst_hi[31:20]};
        IMM_TYPE_S:   o_imm = {{20{i_inst_hi[31]}}, i_inst_hi[31:25], i_inst_hi[11:7]};
        IMM_TYPE_B:   o_imm = {{19{i_inst_hi[31]}}, i_inst_hi[31], i_inst_hi[7],
                               i_inst_hi[30:25], i_inst_hi[11:8], 1'b0};
        IMM_TYPE_U:   o_imm = {i_inst_hi[31:12], 12'h000};
        IMM_TYPE_J:   o_imm = {{11{i_inst_hi[31]}}, i_inst_hi[31], i_inst_hi[19:12],
                               i_inst_hi[20], i_inst_hi[30:21], 1'b0};
        IMM_TYPE_CSR: o_imm = {27'd0, i_inst_hi[19:15]};
        default:      o_imm = '0;
      endcase
    end
  end

endmodule

// Decode/immediate stage between fetch and execute.
// Latency: accepted at edge N, visible on o_* after edge N.
// Backpressure: SKID_EN=1 ready = !skid_valid (registered); SKID_EN=0 ready = !o_valid | i_ready.
module decode_imm_stage
  import decode_imm_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  inst_t           i_in_inst,
  input  logic [PC_W-1:0] i_in_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output inst_t           o_inst,
  output logic [PC_W-1:0] o_pc,
  output word_t           o_imm,
  output imm_type_e       o_imm_type,
  output logic            o_imm_used,
  output logic            o_illegal
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    inst_t           inst;
    word_t           imm;
    imm_type_e       imm_type;
    logic            imm_used;
    logic            illegal;
  } entry_t;

  imm_type_e dec_type;
  logic      dec_used;
  logic      dec_illegal;
  word_t     dec_imm;
  entry_t    dec_entry;
  logic      in_fire;

  entry_t main_q, main_d;
  logic   main_vld_q, main_vld_d;

  // Opcode classification; an illegal word never reports an immediate
  always_comb begin
    dec_type    = IMM_TYPE_I;
    dec_used    = 1'b0;
    dec_illegal = 1'b0;
    case (i_in_inst[6:0])
      OP_LUI, OP_AUIPC: begin
        dec_type = IMM_TYPE_U;
        dec_used = 1'b1;
      end
      OP_JAL: begin
        dec_type = IMM_TYPE_J;
        dec_used = 1'b1;
      end
      OP_BRANCH: begin
        dec_type = IMM_TYPE_B;
        dec_used = 1'b1;
      end
      OP_STORE: begin
        dec_type = IMM_TYPE_S;
        dec_used = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE: begin
        dec_type = IMM_TYPE_I;
        dec_used = 1'b1;
      end
      OP_REG: begin
        dec_used = 1'b0;
      end
      OP_SYSTEM: begin
        if (i_in_inst[14]) begin
          dec_type = IMM_TYPE_CSR;
          dec_used = 1'b1;
        end else if (i_in_inst[13:12] != 2'b00) begin
          dec_type = IMM_TYPE_I;
          dec_used = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    // Compressed-space encodings are not supported by this stage
    if (i_in_inst[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end
    if (dec_illegal) begin
      dec_type = IMM_TYPE_I;
      dec_used = 1'b0;
    end
  end

  decode_imm_gen u_imm_gen (
    .i_inst_hi (i_in_inst[31:7]),
    .i_type    (dec_type),
    .i_en      (dec_used),
    .o_imm     (dec_imm)
  );

  assign dec_entry = '{pc:       i_in_pc,
                       inst:     i_in_inst,
                       imm:      dec_imm,
                       imm_type: dec_type,
                       imm_used: dec_used,
                       illegal:  dec_illegal};

  assign in_fire = i_in_valid & o_in_ready;

  generate
    if (SKID_EN) begin : g_skid
      entry_t skid_q, skid_d;
      logic   skid_vld_q, skid_vld_d;

      assign o_in_ready = !skid_vld_q;

      // Two-slot steering: main drains first, skid catches input while main is stalled
      always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (i_flush) begin
          main_vld_d = 1'b0;
          skid_vld_d = 1'b0;
        end else if (!main_vld_q || i_ready) begin
          if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
          end else begin
            main_vld_d = in_fire;
            if (in_fire) begin
              main_d = dec_entry;
            end
          end
        end else if (in_fire) begin
          skid_d     = dec_entry;
          skid_vld_d = 1'b1;
        end
      end

      // Skid slot storage
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          skid_q     <= '0;
          skid_vld_q <= 1'b0;
        end else begin
          skid_q     <= skid_d;
          skid_vld_q <= skid_vld_d;
        end
      end
    end else begin : g_noskid
      assign o_in_ready = !main_vld_q | i_ready;

      // Single slot: load on accept, empty on consume, flush wins
      always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (i_flush) begin
          main_vld_d = 1'b0;
        end else if (in_fire) begin
          main_d     = dec_entry;
          main_vld_d = 1'b1;
        end else if (i_ready) begin
          main_vld_d = 1'b0;
        end
      end
    end
  endgenerate

  // D/E pipeline register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
    end
  end

  assign o_valid    = main_vld_q;
  assign o_inst     = main_q.inst;
  assign o_pc       = main_q.pc;
  assign o_imm      = main_q.imm;
  assign o_imm_type = main_q.imm_type;
  assign o_imm_used = main_q.imm_used;
  assign o_illegal  = main_q.illegal;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Bench for decode_imm_stage: both SKID_EN builds run side by side against a queue model.
// Latency: model expects an accepted entry at the queue head one edge later.
// Backpressure: model capacity is 2 (skid) or 1 (no skid) and predicts o_in_ready.
module tb_decode_imm_stage;
  import decode_imm_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    imm_type_e   ty;
    bit          used;
    bit          ill;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;
  int ndone = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    logic [31:0] m;
    logic [31:0] s;
    m = (32'd1 << n) - 32'd1;
    s = 32'd1 << (n - 1);
    return ((v & m) ^ s) - s;
  endfunction

  // Reference decode straight from the opcode table and immediate formats
  function automatic ent_t ref_decode(input logic [31:0] w, input logic [31:0] p);
    ent_t e;
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    e.pc = p; e.inst = w; e.imm = 0; e.ty = IMM_TYPE_I; e.used = 0; e.ill = 0;
    if (w[1:0] != 2'b11) e.ill = 1;
    else if (op == 7'b0110111 || op == 7'b0010111) begin e.ty = IMM_TYPE_U; e.used = 1; end
    else if (op == 7'b1101111) begin e.ty = IMM_TYPE_J; e.used = 1; end
    else if (op == 7'b1100011) begin e.ty = IMM_TYPE_B; e.used = 1; end
    else if (op == 7'b0100011) begin e.ty = IMM_TYPE_S; e.used = 1; end
    else if (op == 7'b1100111 || op == 7'b0000011 || op == 7'b0010011 || op == 7'b0001111) begin
      e.ty = IMM_TYPE_I; e.used = 1;
    end
    else if (op == 7'b0110011) e.used = 0;
    else if (op == 7'b1110011) begin
      if (f3 >= 4) begin e.ty = IMM_TYPE_CSR; e.used = 1; end
      else if (f3 != 0) begin e.ty = IMM_TYPE_I; e.used = 1; end
    end
    else e.ill = 1;
    if (e.used) begin
      case (e.ty)
        IMM_TYPE_I:   e.imm = sext(w >> 20, 12);
        IMM_TYPE_S:   e.imm = sext(((w >> 25) << 5) | ((w >> 7) & 32'h1F), 12);
        IMM_TYPE_B:   e.imm = sext({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
        IMM_TYPE_U:   e.imm = w & 32'hFFFFF000;
        IMM_TYPE_J:   e.imm = sext({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
        default:      e.imm = (w >> 15) & 32'h1F;
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  op;
    int          k;
    r = $urandom();
    k = $urandom_range(0, 14);
    case (k)
      0: op = 7'b0110111;  1: op = 7'b0010111;  2: op = 7'b1101111;
      3: op = 7'b1100111;  4: op = 7'b1100011;  5: op = 7'b0000011;
      6: op = 7'b0100011;  7: op = 7'b0010011;  8: op = 7'b0110011;
      9: op = 7'b0001111;  10, 11: op = 7'b1110011;
      default: return r;
    endcase
    return {r[31:7], op};
  endfunction

  // Pin the reference model to hand-computed values
  initial begin
    ent_t e;
    e = ref_decode(32'hFFF00093, 32'h100);
    chk("pin.addi.imm", e.imm, 32'hFFFFFFFF);
    e = ref_decode(32'h12345037, 0);
    chk("pin.lui.imm", e.imm, 32'h12345000);
    chk("pin.lui.type", 32'(e.ty), 32'(IMM_TYPE_U));
    e = ref_decode(32'hFE000EE3, 0);
    chk("pin.beq.imm", e.imm, 32'hFFFFFFFC);
    e = ref_decode(32'h3002D073, 0);
    chk("pin.csrrwi.imm", e.imm, 32'h5);
    chk("pin.csrrwi.type", 32'(e.ty), 32'(IMM_TYPE_CSR));
    e = ref_decode(32'hFE112C23, 0); // sw x1,-8(x2)
    chk("pin.sw.imm", e.imm, 32'hFFFFFFF8);
    e = ref_decode(32'hFF9FF0EF, 0); // jal x1,-8
    chk("pin.jal.imm", e.imm, 32'hFFFFFFF8);
    e = ref_decode(32'h0000007F, 0);
    chk1("pin.bad.ill", e.ill, 1'b1);
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam bit SKID = (gi == 0);

    logic        rst, flush, in_valid, in_ready, ready, o_valid, o_used, o_ill;
    logic [31:0] in_inst, in_pc, o_inst, o_pc, o_imm;
    imm_type_e   o_ty;
    ent_t        q[$];
    string       tag;

    decode_imm_stage #(.PC_W(32), .SKID_EN(SKID)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_flush    (flush),
      .i_in_valid (in_valid),
      .o_in_ready (in_ready),
      .i_in_inst  (in_inst),
      .i_in_pc    (in_pc),
      .o_valid    (o_valid),
      .i_ready    (ready),
      .o_inst     (o_inst),
      .o_pc       (o_pc),
      .o_imm      (o_imm),
      .o_imm_type (o_ty),
      .o_imm_used (o_used),
      .o_illegal  (o_ill)
    );

    // One cycle: drive, compare against the model, then advance the model
    task automatic step(input bit v, input logic [31:0] w, input logic [31:0] p,
                        input bit rd, input bit fl, output bit acc);
      bit   ev, er, inf, outf;
      ent_t e;
      @(negedge clk);
      in_valid = v; in_inst = w; in_pc = p; ready = rd; flush = fl;
      #1;
      ev = (q.size() != 0);
      er = SKID ? (q.size() < 2) : (!ev || rd);
      chk1({tag, ".o_valid"}, o_valid, ev);
      chk1({tag, ".o_in_ready"}, in_ready, er);
      if (ev) begin
        e = q[0];
        chk({tag, ".o_inst"}, o_inst, e.inst);
        chk({tag, ".o_pc"}, o_pc, e.pc);
        chk({tag, ".o_imm"}, o_imm, e.imm);
        chk({tag, ".o_imm_type"}, 32'(o_ty), 32'(e.ty));
        chk1({tag, ".o_imm_used"}, o_used, e.used);
        chk1({tag, ".o_illegal"}, o_ill, e.ill);
      end
      inf  = v && er;
      outf = ev && rd;
      acc  = inf && !fl;
      if (fl) q.delete();
      else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(ref_decode(w, p));
      end
      @(posedge clk);
    endtask

    task automatic async_rst();
      @(negedge clk);
      in_valid = 0; ready = 0; flush = 0;
      #2 rst = 1;
      #1;
      chk1({tag, ".arst.o_valid"}, o_valid, 1'b0);
      chk1({tag, ".arst.o_in_ready"}, in_ready, 1'b1);
      #1 rst = 0;
      q.delete();
    endtask

    initial begin
      bit          a;
      int          nacc, idx;
      logic [31:0] w4 [4];
      tag = SKID ? "skid1" : "skid0";
      rst = 1; flush = 0; in_valid = 0; ready = 0; in_inst = 0; in_pc = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      #1;
      chk1({tag, ".rst.o_valid"}, o_valid, 1'b0);
      chk1({tag, ".rst.o_in_ready"}, in_ready, 1'b1);
      chk({tag, ".rst.o_inst"}, o_inst, 0);
      chk({tag, ".rst.o_pc"}, o_pc, 0);
      chk({tag, ".rst.o_imm"}, o_imm, 0);
      chk({tag, ".rst.o_imm_type"}, 32'(o_ty), 32'(IMM_TYPE_I));
      chk1({tag, ".rst.o_imm_used"}, o_used, 1'b0);
      chk1({tag, ".rst.o_illegal"}, o_ill, 1'b0);

      // Directed decode examples with literal expectations
      step(1, 32'hFFF00093, 32'h100, 0, 0, a);
      #1;
      chk1({tag, ".lit.addi.valid"}, o_valid, 1'b1);
      chk({tag, ".lit.addi.imm"}, o_imm, 32'hFFFFFFFF);
      chk({tag, ".lit.addi.pc"}, o_pc, 32'h100);
      step(1, 32'h12345037, 32'h104, 1, 0, a);
      #1 chk({tag, ".lit.lui.imm"}, o_imm, 32'h12345000);
      step(1, 32'hFE000EE3, 32'h108, 1, 0, a);
      #1 chk({tag, ".lit.beq.imm"}, o_imm, 32'hFFFFFFFC);
      chk({tag, ".lit.beq.type"}, 32'(o_ty), 32'(IMM_TYPE_B));
      step(1, 32'h3002D073, 32'h10C, 1, 0, a);
      #1 chk({tag, ".lit.csr.imm"}, o_imm, 32'h5);
      step(1, 32'h002081B3, 32'h110, 1, 0, a);
      #1 chk1({tag, ".lit.add.used"}, o_used, 1'b0);
      chk({tag, ".lit.add.imm"}, o_imm, 0);
      step(1, 32'h0000007F, 32'h114, 1, 0, a);
      #1 chk1({tag, ".lit.bad.ill"}, o_ill, 1'b1);
      chk({tag, ".lit.bad.imm"}, o_imm, 0);
      step(0, 0, 0, 1, 0, a);

      // Four-instruction stream with execute stalled for three cycles
      w4[0] = 32'h00100093; w4[1] = 32'h00200113; w4[2] = 32'h00300193; w4[3] = 32'h00400213;
      idx = 0;
      for (int c = 0; c < 20 && (idx < 4 || q.size() != 0); c++) begin
        step(idx < 4, (idx < 4) ? w4[idx] : 32'h0, 32'h200 + 4 * idx, c >= 3, 0, a);
        if (a) idx++;
      end
      chk({tag, ".bp.all_accepted"}, idx, 4);

      // Flush with both slots occupied and a new instruction offered
      step(1, 32'h00500293, 32'h300, 0, 0, a);
      step(1, 32'h00600313, 32'h304, 0, 0, a);
      step(1, 32'h00700393, 32'h308, 0, 1, a);
      step(0, 0, 0, 1, 0, a);

      // Asynchronous reset while an instruction is held
      step(1, 32'h00800413, 32'h400, 0, 0, a);
      async_rst();

      // Random traffic
      nacc = 0;
      for (int c = 0; c < 30000 && nacc < 10000; c++) begin
        if ($urandom_range(0, 999) < 2 && q.size() != 0) async_rst();
        else begin
          step($urandom_range(0, 9) < 8, rand_inst(), $urandom(),
               $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, a);
          if (a) nacc++;
        end
      end
      chk1({tag, ".rand.accepted_10k"}, nacc >= 10000, 1'b1);
      in_valid = 0;
      ndone++;
    end
  end

  initial begin
    for (int t = 0; t < 45000 && ndone < 2; t++) @(posedge clk);
    if (ndone < 2) begin
      nvec++;
      nfail++;
      $display("FAIL timeout: %0d of 2 instances finished, required 2", ndone);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
